// File: rtl/cdb_arbiter_if.sv
// Result-offer and broadcast signals between the execution units and the
// common-data-bus arbiter.
interface cdb_arbiter_if #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic [ROB_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              ls_valid;
    logic [ROB_W-1:0]  ls_tag;
    logic [DATA_W-1:0] ls_data;
    logic              ls_ready;

    logic              br_valid;
    logic [ROB_W-1:0]  br_tag;
    logic [DATA_W-1:0] br_data;
    logic              br_ready;

    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_rob_tag;
    logic [DATA_W-1:0] cdb_data;

    modport master (
        output alu_valid, alu_tag, alu_data,
        output ls_valid, ls_tag, ls_data,
        output br_valid, br_tag, br_data,
        input  alu_ready, ls_ready, br_ready,
        input  cdb_valid, cdb_rob_tag, cdb_data
    );

    modport slave (
        input  alu_valid, alu_tag, alu_data,
        input  ls_valid, ls_tag, ls_data,
        input  br_valid, br_tag, br_data,
        output alu_ready, ls_ready, br_ready,
        output cdb_valid, cdb_rob_tag, cdb_data
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per execution unit, round-robin
// grant among full slots, one registered broadcast per cycle.
module cdb_slot #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              flush,
    input  logic              valid,
    input  logic [ROB_W-1:0]  tag,
    input  logic [DATA_W-1:0] data,
    input  logic              grant,
    output logic              ready,
    output logic              full,
    output logic [ROB_W-1:0]  buf_tag,
    output logic [DATA_W-1:0] buf_data
);
    // A slot being drained this cycle can take a new result at the same edge.
    assign ready = ena & ~flush & (~full | grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            buf_tag  <= '0;
            buf_data <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (ena) begin
            if (valid && ready && tag != '0) begin
                full     <= 1'b1;
                buf_tag  <= tag;
                buf_data <= data;
            end else if (grant) begin
                full <= 1'b0;
            end
        end
    end
endmodule

module cdb_arbiter #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int NREQ = 3;

    logic [NREQ-1:0]             valid, ready, full, grant;
    logic [NREQ-1:0][ROB_W-1:0]  tag, buf_tag;
    logic [NREQ-1:0][DATA_W-1:0] data, buf_data;
    logic [1:0]                  last_winner, win, idx;
    logic                        any;

    assign valid = {bus.br_valid, bus.ls_valid, bus.alu_valid};
    assign tag   = {bus.br_tag,   bus.ls_tag,   bus.alu_tag};
    assign data  = {bus.br_data,  bus.ls_data,  bus.alu_data};

    assign bus.alu_ready = ready[0];
    assign bus.ls_ready  = ready[1];
    assign bus.br_ready  = ready[2];

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        cdb_slot #(.ROB_W(ROB_W), .DATA_W(DATA_W)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .flush    (flush),
            .valid    (valid[i]),
            .tag      (tag[i]),
            .data     (data[i]),
            .grant    (grant[i]),
            .ready    (ready[i]),
            .full     (full[i]),
            .buf_tag  (buf_tag[i]),
            .buf_data (buf_data[i])
        );
    end

    // Round-robin: scan starting just after the previous winner.
    always_comb begin
        grant = '0;
        win   = 2'd0;
        any   = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = 2'((int'(last_winner) + 1 + k) % NREQ);
            if (!any && full[idx]) begin
                grant[idx] = 1'b1;
                win        = idx;
                any        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cdb_valid   <= 1'b0;
            bus.cdb_rob_tag <= '0;
            bus.cdb_data    <= '0;
            last_winner     <= 2'd2;
        end else if (flush) begin
            bus.cdb_valid   <= 1'b0;
            bus.cdb_rob_tag <= '0;
            last_winner     <= 2'd2;
        end else if (ena) begin
            if (any) begin
                bus.cdb_valid   <= 1'b1;
                bus.cdb_rob_tag <= buf_tag[win];
                bus.cdb_data    <= buf_data[win];
                last_winner     <= win;
            end else begin
                // Tag forced to zero so idle cycles never match a waiting consumer.
                bus.cdb_valid   <= 1'b0;
                bus.cdb_rob_tag <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a scoreboard of expected broadcasts is
// filled as results are offered and drained by a bus monitor.
module tb_cdb_arbiter;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic flush = 1'b0;
    logic live = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [ROB_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb[$];

    cdb_arbiter_if #(.ROB_W(ROB_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic idle_offers();
        bus.alu_valid = 1'b0; bus.alu_tag = '0; bus.alu_data = '0;
        bus.ls_valid  = 1'b0; bus.ls_tag  = '0; bus.ls_data  = '0;
        bus.br_valid  = 1'b0; bus.br_tag  = '0; bus.br_data  = '0;
    endtask

    task automatic push(input logic [ROB_W-1:0] t, input logic [DATA_W-1:0] d);
        exp_t e;
        e.tag  = t;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // An edge is a new broadcast only when the arbiter was allowed to advance.
    always @(posedge clk) live = ena && !flush && !rst;

    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.cdb_valid)
                chk("idle_tag_zero", 64'(bus.cdb_rob_tag), 64'd0);
            else if (live) begin
                if (sb.size() == 0)
                    chk("unexpected_bcast_tag", 64'(bus.cdb_rob_tag), 64'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("bcast_tag", 64'(bus.cdb_rob_tag), 64'(e.tag));
                    chk("bcast_data", 64'(bus.cdb_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        idle_offers();
        cycles(2);
        chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_tag", 64'(bus.cdb_rob_tag), 64'd0);
        chk("rst_data", 64'(bus.cdb_data), 64'd0);
        rst = 1'b0;
        cycles(1);

        // single result
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd3; bus.alu_data = 32'h11;
        #1 chk("single_alu_ready", 64'(bus.alu_ready), 64'd1);
        push(4'd3, 32'h11);
        cycles(1);
        idle_offers();
        chk("single_not_yet", 64'(bus.cdb_valid), 64'd0);
        cycles(1);
        chk("single_bcast_valid", 64'(bus.cdb_valid), 64'd1);
        chk("single_bcast_tag", 64'(bus.cdb_rob_tag), 64'd3);
        cycles(1);
        chk("single_one_cycle", 64'(bus.cdb_valid), 64'd0);

        // three-way contention starting from last_winner=2
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd1; bus.alu_data = 32'hA1;
        bus.ls_valid  = 1'b1; bus.ls_tag  = 4'd2; bus.ls_data  = 32'hA2;
        bus.br_valid  = 1'b1; bus.br_tag  = 4'd3; bus.br_data  = 32'hA3;
        push(4'd1, 32'hA1); push(4'd2, 32'hA2); push(4'd3, 32'hA3);
        cycles(1);
        idle_offers();
        #1;
        chk("cont_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("cont_ls_ready", 64'(bus.ls_ready), 64'd0);
        chk("cont_br_ready", 64'(bus.br_ready), 64'd0);
        cycles(1);
        chk("cont_t1", 64'(bus.cdb_rob_tag), 64'd1);
        cycles(1);
        chk("cont_t2", 64'(bus.cdb_rob_tag), 64'd2);
        cycles(1);
        chk("cont_t3", 64'(bus.cdb_rob_tag), 64'd3);
        cycles(2);

        // streaming with refill
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd4; bus.alu_data = 32'hB4;
        push(4'd4, 32'hB4);
        cycles(1);
        bus.alu_tag = 4'd5; bus.alu_data = 32'hB5;
        #1 chk("stream_ready5", 64'(bus.alu_ready), 64'd1);
        push(4'd5, 32'hB5);
        cycles(1);
        bus.alu_tag = 4'd6; bus.alu_data = 32'hB6;
        #1 chk("stream_ready6", 64'(bus.alu_ready), 64'd1);
        push(4'd6, 32'hB6);
        chk("stream_t4", 64'(bus.cdb_rob_tag), 64'd4);
        cycles(1);
        idle_offers();
        chk("stream_t5", 64'(bus.cdb_rob_tag), 64'd5);
        cycles(1);
        chk("stream_t6", 64'(bus.cdb_rob_tag), 64'd6);
        cycles(2);

        // flush with LS and BR pending: neither may appear
        bus.ls_valid = 1'b1; bus.ls_tag = 4'd7; bus.ls_data = 32'hC7;
        bus.br_valid = 1'b1; bus.br_tag = 4'd8; bus.br_data = 32'hC8;
        cycles(1);
        idle_offers();
        flush = 1'b1;
        #1 chk("flush_ls_ready", 64'(bus.ls_ready), 64'd0);
        cycles(1);
        flush = 1'b0;
        chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
        chk("flush_tag", 64'(bus.cdb_rob_tag), 64'd0);
        cycles(4);

        // enable low freezes everything, nothing lost afterwards
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd9;  bus.alu_data = 32'hD9;
        bus.br_valid  = 1'b1; bus.br_tag  = 4'd10; bus.br_data  = 32'hDA;
        push(4'd9, 32'hD9); push(4'd10, 32'hDA);
        cycles(1);
        idle_offers();
        cycles(1);
        ena = 1'b0;
        bus.ls_valid = 1'b1; bus.ls_tag = 4'd13; bus.ls_data = 32'hDD;
        #1;
        chk("ena0_alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("ena0_ls_ready", 64'(bus.ls_ready), 64'd0);
        chk("ena0_br_ready", 64'(bus.br_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            chk("ena0_frozen_valid", 64'(bus.cdb_valid), 64'd1);
            chk("ena0_frozen_tag", 64'(bus.cdb_rob_tag), 64'd9);
        end
        ena = 1'b1;
        idle_offers();
        cycles(1);
        chk("ena1_resume_tag", 64'(bus.cdb_rob_tag), 64'd10);
        cycles(2);

        // asynchronous reset mid-operation
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd11; bus.alu_data = 32'hE1;
        push(4'd11, 32'hE1);
        cycles(1);
        idle_offers();
        bus.ls_valid = 1'b1; bus.ls_tag = 4'd12; bus.ls_data = 32'hE2;
        cycles(1);
        idle_offers();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("arst_tag", 64'(bus.cdb_rob_tag), 64'd0);
        chk("arst_data", 64'(bus.cdb_data), 64'd0);
        cycles(1);
        rst = 1'b0;
        cycles(4);

        // zero tag is consumed but never broadcast
        bus.br_valid = 1'b1; bus.br_tag = 4'd0; bus.br_data = 32'h55;
        #1 chk("zero_tag_ready", 64'(bus.br_ready), 64'd1);
        cycles(1);
        idle_offers();
        cycles(3);
        chk("zero_tag_no_bcast", 64'(bus.cdb_valid), 64'd0);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
